ex_mem_skid_stage: RTL and testbench

EX_MEM_SKID_STAGE -- requirements
Module: ex_mem_skid_stage

---
 rtl/ex_mem_skid_stage.sv | 125 ++++++++++++
 tb/tb_ex_mem_skid_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline register with a one-deep skid entry, stall-vector hold/bubble
// handling, synchronous flush and a saturating bubble counter.
module ex_mem_skid_stage #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned REG_W   = 3,
    parameter int unsigned CTRL_W  = 4,
    parameter int unsigned STALL_W = 6,
    parameter int unsigned STAGE   = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [STALL_W-1:0]  stall_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_W-1:0]   in_data1_i,
    input  logic [DATA_W-1:0]   in_result_i,
    input  logic [REG_W-1:0]    in_reg3_i,
    input  logic [CTRL_W-1:0]   in_ctrl_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_W-1:0]   out_data1_o,
    output logic [DATA_W-1:0]   out_result_o,
    output logic [REG_W-1:0]    out_reg3_o,
    output logic [CTRL_W-1:0]   out_ctrl_o,
    output logic [1:0]          occupancy_o,
    output logic [15:0]         bubble_cnt_o
);

    localparam int unsigned ENTRY_W = 2*DATA_W + REG_W + CTRL_W;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ENTRY_W-1:0]   main_q, main_d;
    logic [ENTRY_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]     bub_q, bub_d;
    logic [ENTRY_W-1:0]   in_entry;
    logic                 hold, bubble, accept, drain;
    logic                 unused_stall;

    assign unused_stall = ^stall_i;

    assign hold     = stall_i[STAGE] &  stall_i[STAGE-1];
    assign bubble   = stall_i[STAGE] & ~stall_i[STAGE-1];
    assign in_entry = {in_ctrl_i, in_reg3_i, in_result_i, in_data1_i};

    assign in_ready_o  = (state_q != ST_TWO) & ~stall_i[STAGE] & ~flush_i;
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = out_valid_o & out_ready_i & ~hold & ~flush_i;

    // All outputs are decoded straight from registers.
    assign out_valid_o = (state_q != ST_EMPTY);
    assign occupancy_o = 2'(state_q);
    assign {out_ctrl_o, out_reg3_o, out_result_o, out_data1_o} = main_q;
    assign bubble_cnt_o = bub_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            bub_q   <= bub_d;
        end
    end

    // Next state; hold needs no branch since it already blocks accept and drain.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        bub_d   = bub_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            if (bubble && (bub_q != {CNT_W{1'b1}})) begin
                bub_d = bub_q + CNT_W'(1);
            end
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = ST_TWO;
                    end else if (drain) begin
                        main_d  = '0;
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Randomized and directed bench for ex_mem_skid_stage against a queue-based model.
module tb_ex_mem_skid_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_data1_i, in_result_i;
    logic [2:0]  in_reg3_i;
    logic [3:0]  in_ctrl_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_data1_o, out_result_o;
    logic [2:0]  out_reg3_o;
    logic [3:0]  out_ctrl_o;
    logic [1:0]  occupancy_o;
    logic [15:0] bubble_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [38:0] mq[$];
    logic [15:0] m_bub;

    always #5 clk = ~clk;

    ex_mem_skid_stage dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data1_i   (in_data1_i),
        .in_result_i  (in_result_i),
        .in_reg3_i    (in_reg3_i),
        .in_ctrl_i    (in_ctrl_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data1_o  (out_data1_o),
        .out_result_o (out_result_o),
        .out_reg3_o   (out_reg3_o),
        .out_ctrl_o   (out_ctrl_o),
        .occupancy_o  (occupancy_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [38:0] exp_e;
        exp_e = (mq.size() > 0) ? mq[0] : 39'd0;
        chk({tag, ".valid"}, 64'(out_valid_o), 64'(mq.size() > 0));
        chk({tag, ".occ"}, 64'(occupancy_o), 64'(mq.size()));
        chk({tag, ".entry"}, 64'({out_ctrl_o, out_reg3_o, out_result_o, out_data1_o}), 64'(exp_e));
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt_o), 64'(m_bub));
    endtask

    // One clock cycle: drive, check ready, advance model, check outputs.
    task automatic cyc(input string tag, input logic v, input logic [15:0] d1,
                       input logic [15:0] res, input logic [2:0] r3, input logic [3:0] ct,
                       input logic ordy, input logic [5:0] st, input logic fl);
        logic h, b, exp_rdy, acc, drn;
        in_valid_i = v; in_data1_i = d1; in_result_i = res; in_reg3_i = r3; in_ctrl_i = ct;
        out_ready_i = ordy; stall_i = st; flush_i = fl;
        #1;
        h = st[2] & st[1];
        b = st[2] & ~st[1];
        exp_rdy = (mq.size() < 2) && !st[2] && !fl;
        chk({tag, ".in_ready"}, 64'(in_ready_o), 64'(exp_rdy));
        acc = v & exp_rdy;
        drn = (mq.size() > 0) && ordy && !h && !fl;
        @(posedge clk); #1;
        if (fl) mq.delete();
        else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back({ct, r3, res, d1});
            if (b && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
        end
        check_outputs(tag);
    endtask

    task automatic word(input string tag, input logic [15:0] d, input logic ordy, input logic [5:0] st);
        cyc(tag, 1'b1, d, ~d, d[2:0], d[3:0], ordy, st, 1'b0);
    endtask

    task automatic idle(input string tag, input logic ordy, input logic [5:0] st);
        cyc(tag, 1'b0, 16'h0, 16'h0, 3'h0, 4'h0, ordy, st, 1'b0);
    endtask

    initial begin
        rst_i = 1'b0; stall_i = '0; flush_i = 1'b0; in_valid_i = 1'b0;
        in_data1_i = '0; in_result_i = '0; in_reg3_i = '0; in_ctrl_i = '0; out_ready_i = 1'b0;
        m_bub = '0;
        #2;
        check_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rst_i = 1'b1;
        @(posedge clk); #1;

        // Streaming at full throughput
        for (int i = 1; i <= 4; i++) word("stream", 16'(i), 1'b1, 6'b0);
        idle("stream_end", 1'b1, 6'b0);

        // Fill both entries, then drain in order
        word("fill_a", 16'hAAAA, 1'b0, 6'b0);
        word("fill_b", 16'hBBBB, 1'b0, 6'b0);
        word("full_blocked", 16'hCCCC, 1'b0, 6'b0);
        idle("drain1", 1'b1, 6'b0);
        idle("drain2", 1'b1, 6'b0);

        // Hold freezes a single entry
        word("load_1234", 16'h1234, 1'b0, 6'b0);
        for (int i = 0; i < 3; i++) word("hold", 16'h5555, 1'b1, 6'b000110);
        idle("after_hold", 1'b1, 6'b0);

        // Bubble blocks input but still drains
        word("pre_bub_a", 16'h1111, 1'b0, 6'b0);
        word("pre_bub_b", 16'h2222, 1'b0, 6'b0);
        for (int i = 0; i < 5; i++) word("bubble", 16'h7777, 1'b1, 6'b000100);
        chk("bubble_cnt_five", 64'(bubble_cnt_o), 64'd5);

        // Flush beats hold while full
        word("pre_fl_a", 16'h3333, 1'b0, 6'b0);
        word("pre_fl_b", 16'h4444, 1'b0, 6'b0);
        cyc("flush_hold", 1'b1, 16'h9999, 16'h9999, 3'h7, 4'hF, 1'b1, 6'b000110, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] st;
            int unsigned r;
            r = $urandom_range(0, 9);
            st = 6'($urandom) & 6'b111001;
            if (r == 0) st = st | 6'b000110;
            else if (r == 1) st = st | 6'b000100;
            else if (r == 2) st = st | 6'b000010;
            cyc("rand", 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 4'($urandom),
                1'($urandom_range(0, 3) != 0), st, $urandom_range(0, 39) == 0);
        end

        // Asynchronous reset mid-cycle while full
        word("pre_rst_a", 16'hA5A5, 1'b0, 6'b0);
        word("pre_rst_b", 16'h5A5A, 1'b0, 6'b0);
        in_valid_i = 1'b1; in_data1_i = 16'hBEEF; in_result_i = 16'hCAFE;
        in_reg3_i = 3'h5; in_ctrl_i = 4'hA; out_ready_i = 1'b0; stall_i = '0;
        #2 rst_i = 1'b0;
        #1;
        mq.delete(); m_bub = '0;
        check_outputs("async_rst");
        @(negedge clk); rst_i = 1'b1;
        @(posedge clk); #1;
        mq.push_back({4'hA, 3'h5, 16'hCAFE, 16'hBEEF});
        check_outputs("first_accept");
        idle("post_rst_drain", 1'b1, 6'b0);

        // Saturate the bubble counter
        in_valid_i = 1'b0; stall_i = 6'b000100; out_ready_i = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        m_bub = 16'hFFFF;
        check_outputs("saturate");
        idle("saturate_hold", 1'b1, 6'b000100);
        idle("saturate_again", 1'b1, 6'b000100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
